// File: rtl/cpu_pkg.sv
// cpu_pkg
// Types and default constants that the CPU front-end blocks share.
//   jump_sel_t  : redirect kind resolved in EXEC (none / register / page / PC-relative)
//   seq_state_t : states of the FETCH/EXEC sequencer
//   DEF_RESET_VECTOR, DEF_HALT_ADDR : default parameter values for pc_sequencer
package cpu_pkg;

  typedef enum logic [1:0] {
    JS_NONE = 2'b00,
    JS_REG  = 2'b01,
    JS_PAGE = 2'b10,
    JS_REL  = 2'b11
  } jump_sel_t;

  typedef enum logic [1:0] {
    S_FETCH  = 2'b00,
    S_EXEC   = 2'b01,
    S_HALTED = 2'b10
  } seq_state_t;

  localparam logic [31:0] DEF_RESET_VECTOR = 32'hBFC0_0000;
  localparam logic [31:0] DEF_HALT_ADDR    = 32'h0000_0000;

endpackage : cpu_pkg

// File: rtl/jump_target_calc.sv
// jump_target_calc
// Purely combinational redirect target computation.
//   jump_sel      in  2   redirect kind (jump_sel_t encoding)
//   pc            in  32  address of the instruction doing the redirect
//   rs_value      in  32  register operand for register-absolute jumps
//   instr_index   in  26  page-absolute jump field
//   branch_offset in  16  PC-relative branch word offset
//   target        out 32  computed redirect address (0 when jump_sel is none)
//   misaligned    out 1   target is not word aligned
module jump_target_calc
  import cpu_pkg::*;
(
  input  logic [1:0]  jump_sel,
  input  logic [31:0] pc,
  input  logic [31:0] rs_value,
  input  logic [25:0] instr_index,
  input  logic [15:0] branch_offset,
  output logic [31:0] target,
  output logic        misaligned
);

  logic [31:0] pc_plus4;
  logic [31:0] offset_ext;
  jump_sel_t   sel;

  assign sel      = jump_sel_t'(jump_sel);
  assign pc_plus4 = pc + 32'd4;
  // Word offset: sign-extend the 16-bit field and scale by 4.
  assign offset_ext = {{14{branch_offset[15]}}, branch_offset, 2'b00};

  always_comb begin
    target = 32'h0000_0000;
    case (sel)
      JS_REG:  target = rs_value;
      // Page jumps stay inside the 256 MB region of the delay slot.
      JS_PAGE: target = {pc_plus4[31:28], instr_index, 2'b00};
      JS_REL:  target = pc_plus4 + offset_ext;
      default: target = 32'h0000_0000;
    endcase
  end

  // Only register jumps can produce a misaligned address, but the check is
  // kept generic so the caller never has to know that.
  assign misaligned = (sel != JS_NONE) && (target[1:0] != 2'b00);

endmodule : jump_target_calc

// File: rtl/pc_sequencer.sv
// pc_sequencer
// Two-cycle FETCH/EXEC sequencer that owns the program counter, including
// the one-instruction branch delay slot and halt-on-jump-to-HALT_ADDR.
//   clk           in  1   rising-edge clock
//   reset_n       in  1   asynchronous active-low reset
//   instr_wait    in  1   instruction memory not ready (holds FETCH)
//   data_wait     in  1   data memory not ready (holds EXEC)
//   jump_sel      in  2   redirect kind, sampled on the commit cycle
//   rs_value      in  32  register absolute target
//   instr_index   in  26  page absolute field
//   branch_offset in  16  PC-relative offset
//   state         out 1   0 = FETCH, 1 = EXEC
//   pc            out 32  address of the current instruction
//   instr_read    out 1   instruction memory read strobe
//   link_addr     out 32  pc + 8
//   exec_commit   out 1   instruction retires this cycle
//   in_delay_slot out 1   current instruction is a delay slot
//   active        out 1   CPU running
//   addr_err      out 1   sticky misaligned-redirect error
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
  parameter logic [31:0] HALT_ADDR    = DEF_HALT_ADDR
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        instr_wait,
  input  logic        data_wait,
  input  logic [1:0]  jump_sel,
  input  logic [31:0] rs_value,
  input  logic [25:0] instr_index,
  input  logic [15:0] branch_offset,
  output logic        state,
  output logic [31:0] pc,
  output logic        instr_read,
  output logic [31:0] link_addr,
  output logic        exec_commit,
  output logic        in_delay_slot,
  output logic        active,
  output logic        addr_err
);

  seq_state_t  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        pending_q, pending_d;
  logic [31:0] pend_target_q, pend_target_d;
  logic        addr_err_q, addr_err_d;

  logic [31:0] target;
  logic        misaligned;

  jump_target_calc u_jump_target_calc (
    .jump_sel      (jump_sel),
    .pc            (pc_q),
    .rs_value      (rs_value),
    .instr_index   (instr_index),
    .branch_offset (branch_offset),
    .target        (target),
    .misaligned    (misaligned)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_FETCH;
      pc_q          <= RESET_VECTOR;
      pending_q     <= 1'b0;
      pend_target_q <= 32'h0000_0000;
      addr_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pending_q     <= pending_d;
      pend_target_q <= pend_target_d;
      addr_err_q    <= addr_err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pending_d     = pending_q;
    pend_target_d = pend_target_q;
    addr_err_d    = addr_err_q;
    exec_commit   = 1'b0;

    case (state_q)
      S_FETCH: begin
        if (!instr_wait) state_d = S_EXEC;
      end

      S_EXEC: begin
        // A data stall freezes everything, including any pending redirect.
        if (!data_wait) begin
          exec_commit = 1'b1;
          state_d     = S_FETCH;
          if (pending_q) begin
            // Delay slot retiring: take the deferred redirect; any jump_sel
            // on this instruction is deliberately ignored.
            pc_d      = pend_target_q;
            pending_d = 1'b0;
            if (pend_target_q == HALT_ADDR) state_d = S_HALTED;
          end else begin
            pc_d = pc_q + 32'd4;
            if (jump_sel_t'(jump_sel) != JS_NONE) begin
              if (misaligned) begin
                // Fatal: stop right here, no delay slot runs.
                addr_err_d = 1'b1;
                state_d    = S_HALTED;
              end else begin
                pend_target_d = target;
                pending_d     = 1'b1;
              end
            end
          end
        end
      end

      S_HALTED: begin
        // Terminal until reset.
      end

      default: state_d = S_FETCH;
    endcase
  end

  assign state         = (state_q == S_EXEC);
  assign pc            = pc_q;
  assign active        = (state_q != S_HALTED);
  assign instr_read    = (state_q == S_FETCH);
  assign link_addr     = pc_q + 32'd8;
  assign in_delay_slot = pending_q;
  assign addr_err      = addr_err_q;

endmodule : pc_sequencer

// File: tb/tb_pc_sequencer.sv
// Directed, table-driven bench for pc_sequencer.
module tb_pc_sequencer;

  logic        clk;
  logic        reset_n;
  logic        instr_wait;
  logic        data_wait;
  logic [1:0]  jump_sel;
  logic [31:0] rs_value;
  logic [25:0] instr_index;
  logic [15:0] branch_offset;
  logic        state;
  logic [31:0] pc;
  logic        instr_read;
  logic [31:0] link_addr;
  logic        exec_commit;
  logic        in_delay_slot;
  logic        active;
  logic        addr_err;

  int compared   = 0;
  int mismatched = 0;

  pc_sequencer dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .instr_wait    (instr_wait),
    .data_wait     (data_wait),
    .jump_sel      (jump_sel),
    .rs_value      (rs_value),
    .instr_index   (instr_index),
    .branch_offset (branch_offset),
    .state         (state),
    .pc            (pc),
    .instr_read    (instr_read),
    .link_addr     (link_addr),
    .exec_commit   (exec_commit),
    .in_delay_slot (in_delay_slot),
    .active        (active),
    .addr_err      (addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iw;
    logic        dw;
    logic [1:0]  js;
    logic [31:0] rs;
    logic [25:0] idx;
    logic [15:0] off;
    logic        st;
    logic [31:0] pc;
    logic        ir;
    logic        ec;
    logic        ds;
    logic        act;
    logic        err;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic iw, input logic dw, input logic [1:0] js,
                      input logic [31:0] rs, input logic [25:0] idx, input logic [15:0] off,
                      input logic st, input logic [31:0] epc, input logic ir, input logic ec,
                      input logic ds, input logic act, input logic err);
    vec_t v;
    v.iw = iw; v.dw = dw; v.js = js; v.rs = rs; v.idx = idx; v.off = off;
    v.st = st; v.pc = epc; v.ir = ir; v.ec = ec; v.ds = ds; v.act = act; v.err = err;
    vq.push_back(v);
  endtask

  // One unstalled instruction: a FETCH cycle then a committing EXEC cycle.
  task automatic add_instr(input logic [31:0] epc, input logic ds, input logic [1:0] js,
                           input logic [31:0] rs, input logic [25:0] idx, input logic [15:0] off);
    push(1'b0, 1'b0, 2'b00, 32'h0, 26'h0, 16'h0, 1'b0, epc, 1'b1, 1'b0, ds, 1'b1, 1'b0);
    push(1'b0, 1'b0, js, rs, idx, off, 1'b1, epc, 1'b0, 1'b1, ds, 1'b1, 1'b0);
  endtask

  task automatic add_halted(input logic [31:0] epc, input logic err);
    push(1'b0, 1'b0, 2'b00, 32'h0, 26'h0, 16'h0, 1'b0, epc, 1'b0, 1'b0, 1'b0, 1'b0, err);
  endtask

  // Entered at a negedge; each vector is driven, checked 1 ns later, and the
  // next posedge consumes its inputs.
  task automatic run_vectors(input string tag);
    for (int i = 0; i < vq.size(); i++) begin
      instr_wait    = vq[i].iw;
      data_wait     = vq[i].dw;
      jump_sel      = vq[i].js;
      rs_value      = vq[i].rs;
      instr_index   = vq[i].idx;
      branch_offset = vq[i].off;
      #1;
      $display("%s[%0d] pc=%h state=%0b commit=%0b ds=%0b active=%0b err=%0b",
               tag, i, pc, state, exec_commit, in_delay_slot, active, addr_err);
      chk($sformatf("%s[%0d] state", tag, i), {31'b0, state}, {31'b0, vq[i].st});
      chk($sformatf("%s[%0d] pc", tag, i), pc, vq[i].pc);
      chk($sformatf("%s[%0d] link_addr", tag, i), link_addr, vq[i].pc + 32'd8);
      chk($sformatf("%s[%0d] instr_read", tag, i), {31'b0, instr_read}, {31'b0, vq[i].ir});
      chk($sformatf("%s[%0d] exec_commit", tag, i), {31'b0, exec_commit}, {31'b0, vq[i].ec});
      chk($sformatf("%s[%0d] in_delay_slot", tag, i), {31'b0, in_delay_slot}, {31'b0, vq[i].ds});
      chk($sformatf("%s[%0d] active", tag, i), {31'b0, active}, {31'b0, vq[i].act});
      chk($sformatf("%s[%0d] addr_err", tag, i), {31'b0, addr_err}, {31'b0, vq[i].err});
      @(negedge clk);
    end
    vq = {};
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, " pc"}, pc, 32'hBFC0_0000);
    chk({tag, " state"}, {31'b0, state}, 32'd0);
    chk({tag, " exec_commit"}, {31'b0, exec_commit}, 32'd0);
    chk({tag, " in_delay_slot"}, {31'b0, in_delay_slot}, 32'd0);
    chk({tag, " active"}, {31'b0, active}, 32'd1);
    chk({tag, " addr_err"}, {31'b0, addr_err}, 32'd0);
  endtask

  // Ends at a negedge with reset just released.
  task automatic do_reset();
    instr_wait = 1'b0; data_wait = 1'b0; jump_sel = 2'b00;
    rs_value = 32'h0; instr_index = 26'h0; branch_offset = 16'h0;
    reset_n = 1'b0;
    #1;
    check_reset_state("reset");
    $display("reset pc=%h state=%0b", pc, state);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b1;
    @(negedge clk);
    do_reset();

    // Straight line, BEQ back to BFC00004, J into page B, JR to 0 -> halt.
    add_instr(32'hBFC0_0000, 1'b0, 2'b00, 32'h0, 26'h0, 16'h0);
    add_instr(32'hBFC0_0004, 1'b0, 2'b00, 32'h0, 26'h0, 16'h0);
    add_instr(32'hBFC0_0008, 1'b0, 2'b00, 32'h0, 26'h0, 16'h0);
    add_instr(32'hBFC0_000C, 1'b0, 2'b00, 32'h0, 26'h0, 16'h0);
    add_instr(32'hBFC0_0010, 1'b0, 2'b11, 32'h0, 26'h0, 16'hFFFC);
    add_instr(32'hBFC0_0014, 1'b1, 2'b00, 32'h0, 26'h0, 16'h0);
    for (int i = 0; i < 7; i++)
      add_instr(32'hBFC0_0004 + 32'(4 * i), 1'b0, 2'b00, 32'h0, 26'h0, 16'h0);
    add_instr(32'hBFC0_0020, 1'b0, 2'b10, 32'h0, 26'h000_0100, 16'h0);
    add_instr(32'hBFC0_0024, 1'b1, 2'b00, 32'h0, 26'h0, 16'h0);
    add_instr(32'hB000_0400, 1'b0, 2'b01, 32'h0000_0000, 26'h0, 16'h0);
    add_instr(32'hB000_0404, 1'b1, 2'b00, 32'h0, 26'h0, 16'h0);
    add_halted(32'h0000_0000, 1'b0);
    add_halted(32'h0000_0000, 1'b0);
    run_vectors("flow");

    // Stalls: 3 instr_wait cycles, then 2 data_wait cycles on a taken branch
    // whose operands change while stalled (must not be sampled).
    do_reset();
    for (int i = 0; i < 3; i++)
      push(1'b1, 1'b0, 2'b00, 32'h0, 26'h0, 16'h0, 1'b0, 32'hBFC0_0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    push(1'b0, 1'b0, 2'b00, 32'h0, 26'h0, 16'h0, 1'b0, 32'hBFC0_0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    push(1'b0, 1'b1, 2'b01, 32'h0000_0003, 26'h0, 16'h0, 1'b1, 32'hBFC0_0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    push(1'b0, 1'b1, 2'b11, 32'h0, 26'h0, 16'h0002, 1'b1, 32'hBFC0_0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    push(1'b0, 1'b0, 2'b11, 32'h0, 26'h0, 16'h0002, 1'b1, 32'hBFC0_0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    // Delay slot, stalled in EXEC once: pending redirect must survive.
    push(1'b0, 1'b0, 2'b00, 32'h0, 26'h0, 16'h0, 1'b0, 32'hBFC0_0004, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    push(1'b0, 1'b1, 2'b00, 32'h0, 26'h0, 16'h0, 1'b1, 32'hBFC0_0004, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    push(1'b0, 1'b0, 2'b00, 32'h0, 26'h0, 16'h0, 1'b1, 32'hBFC0_0004, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    // Misaligned JR at the branch target: immediate halt with addr_err.
    add_instr(32'hBFC0_000C, 1'b0, 2'b01, 32'h0040_0002, 26'h0, 16'h0);
    add_halted(32'hBFC0_0010, 1'b1);
    add_halted(32'hBFC0_0010, 1'b1);
    run_vectors("stall");

    // Branch in a delay slot is ignored, then reset in mid-EXEC with pending.
    do_reset();
    add_instr(32'hBFC0_0000, 1'b0, 2'b11, 32'h0, 26'h0, 16'h0004);
    add_instr(32'hBFC0_0004, 1'b1, 2'b10, 32'h0, 26'h3FF_FFFF, 16'h0);
    add_instr(32'hBFC0_0014, 1'b0, 2'b11, 32'h0, 26'h0, 16'h0001);
    push(1'b0, 1'b0, 2'b00, 32'h0, 26'h0, 16'h0, 1'b0, 32'hBFC0_0018, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    run_vectors("nest");

    // Now in EXEC of the delay slot at BFC00018 with a redirect pending.
    data_wait = 1'b1;
    #1;
    chk("mid pre-reset state", {31'b0, state}, 32'd1);
    chk("mid pre-reset ds", {31'b0, in_delay_slot}, 32'd1);
    reset_n = 1'b0;
    #1;
    $display("mid-exec reset pc=%h state=%0b ds=%0b", pc, state, in_delay_slot);
    check_reset_state("mid reset");
    @(negedge clk);
    data_wait = 1'b0;
    reset_n = 1'b1;
    add_instr(32'hBFC0_0000, 1'b0, 2'b00, 32'h0, 26'h0, 16'h0);
    add_instr(32'hBFC0_0004, 1'b0, 2'b00, 32'h0, 26'h0, 16'h0);
    add_instr(32'hBFC0_0008, 1'b0, 2'b00, 32'h0, 26'h0, 16'h0);
    run_vectors("post");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_pc_sequencer

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Multi-cycle FETCH/EXEC sequencer that owns the program counter for the Harvard CPU.
- Generates `state`, which is consumed by branch/jump resolution and by register/memory write enables.
- Captures the jump selection resolved in EXEC and computes the target address.
- Defers the redirect by exactly one instruction to honour the MIPS branch delay slot.
- Detects the halt condition (a jump to address 0) and stalls on instruction/data memory wait.

Parameters:
- RESET_VECTOR, 32'hBFC0_0000, PC value loaded on reset.
- HALT_ADDR, 32'h0000_0000, redirect target that halts the CPU once its delay slot retires.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- instr_wait  in  1  instruction memory not ready; hold FETCH.
- data_wait  in  1  data memory not ready; hold EXEC.
- jump_sel  in  2  00 none, 01 register absolute, 10 page absolute, 11 PC-relative; valid in EXEC.
- rs_value  in  32  register rs contents, used for sel 01.
- instr_index  in  26  instruction[25:0], used for sel 10.
- branch_offset  in  16  instruction[15:0], used for sel 11.
- state  out  1  0 = FETCH, 1 = EXEC.
- pc  out  32  address of the instruction being fetched/executed.
- instr_read  out  1  instruction memory read strobe.
- link_addr  out  32  pc+8, the link value for JAL/JALR/xxAL.
- exec_commit  out  1  one-cycle pulse on the EXEC cycle that retires an instruction.
- in_delay_slot  out  1  the current instruction is a delay slot.
- active  out  1  CPU running; low after halt.
- addr_err  out  1  sticky misaligned-redirect error.

Behaviour:
- Reset (asynchronous, regardless of state; an in-flight fetch is discarded):
  - pc = RESET_VECTOR, state = FETCH, active = 1.
  - pending = 0, addr_err = 0, exec_commit = 0, in_delay_slot = 0.
- FSM states: FETCH, EXEC, HALTED.
  - FETCH: instr_read = active. If instr_wait, stay. Else go to EXEC next cycle.
  - EXEC: if data_wait, stay and assert nothing. Else exec_commit = 1 (combinational in that cycle) and go to FETCH, or to HALTED (see halt).
  - HALTED: terminal until reset. instr_read = 0, active = 0, pc frozen.
- On a commit, when pending = 0:
  - If jump_sel != 00: compute target, store pend_target, set pending = 1.
  - pc <= pc+4 in all cases.
- On a commit, when pending = 1 (this instruction is the delay slot; in_delay_slot = 1 throughout its FETCH and EXEC):
  - pc <= pend_target, pending <= 0.
  - If pend_target == HALT_ADDR, next state is HALTED instead of FETCH.
  - A non-zero jump_sel on a delay-slot instruction is ignored; no nested redirect.
- Target arithmetic (32-bit, wrap modulo 2^32):
  - 01: rs_value.
  - 10: {(pc+4)[31:28], instr_index, 2'b00}.
  - 11: pc + 4 + (sign_extend(branch_offset) << 2).
- Misalignment: if target[1:0] != 0, set addr_err (sticky) and go to HALTED at the same commit. No delay slot executes.
- jump_sel, rs_value, instr_index and branch_offset are sampled only on a commit cycle; they are don't-care otherwise.
- link_addr = pc + 8, combinational.
- Latency:
  - Minimum 2 cycles per instruction.
  - Branch target becomes pc two instructions after the branch (after branch, then delay slot).
- Simultaneous events: a data_wait cycle blocks the commit and all pc/pending updates; a stall never drops a pending redirect.

Decomposition:
- Shared package `cpu_pkg` holds:
  - `jump_sel_t` enum (JS_NONE, JS_REG, JS_PAGE, JS_REL).
  - `seq_state_t` enum (S_FETCH, S_EXEC, S_HALTED).
  - RESET_VECTOR and HALT_ADDR defaults.
- One sub-module, `jump_target_calc`: purely combinational; computes target and misalignment from jump_sel, pc, rs_value, instr_index and branch_offset.
- The FSM, pending register and pc register stay in pc_sequencer.

Test Plan:
- Reset and straight-line: release reset, no waits, jump_sel = 00 → pc sequence BFC00000, BFC00004, BFC00008; state alternates each cycle; one exec_commit pulse per 2 cycles.
- BEQ taken at BFC00010 with offset 16'hFFFC → next pc BFC00014 (in_delay_slot = 1), then BFC00004.
- J at BFC00020 with instr_index 26'h0000100 → after delay slot BFC00024, pc = B0000400. JR with rs_value = 0 → after delay slot, HALTED, active = 0, instr_read = 0, pc frozen.
- Stalls: instr_wait high 3 cycles in FETCH, then data_wait high 2 cycles in EXEC on a taken branch → state held, pc unchanged, exec_commit only after waits drop, and the redirect still lands after the delay slot.
- Misaligned JR, rs_value = 32'h00400002 → addr_err = 1 and HALTED on that commit. A branch placed in a delay slot → its jump_sel is ignored and pc follows the first branch's target.
- Reset asserted mid-EXEC with pending = 1 → pc = BFC00000 and pending cleared immediately (asynchronous). After release, straight-line fetch resumes with no stale redirect.
